// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per handshake into ALU operator and
// operands, held in a one-entry valid/ready output register feeding the ALU.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic [4:0]          rs1_addr,
  output logic [4:0]          rs2_addr,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] alu_operator,
  output logic [XLEN-1:0]     operand1,
  output logic [XLEN-1:0]     operand2,
  output logic [XLEN-1:0]     out_pc,
  output logic [XLEN-1:0]     out_imm,
  output logic [XLEN-1:0]     out_store,
  output logic [4:0]          rd,
  output logic                rd_we,
  output logic                is_branch,
  output logic                illegal
);

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = ALU_OP_W'(4'd0);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = ALU_OP_W'(4'd1);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = ALU_OP_W'(4'd2);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = ALU_OP_W'(4'd3);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = ALU_OP_W'(4'd4);
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = ALU_OP_W'(4'd5);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = ALU_OP_W'(4'd6);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = ALU_OP_W'(4'd7);
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = ALU_OP_W'(4'd8);
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = ALU_OP_W'(4'd9);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SEQ  = ALU_OP_W'(4'd10);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SNE  = ALU_OP_W'(4'd11);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SGE  = ALU_OP_W'(4'd12);
  localparam logic [ALU_OP_W-1:0] ALU_OP_SGEU = ALU_OP_W'(4'd13);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode   = in_instr[6:0];
  assign rd_field = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  logic                out_valid_q, out_valid_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d, op_raw;
  logic [XLEN-1:0]     op1_q, op1_d, op1_raw;
  logic [XLEN-1:0]     op2_q, op2_d, op2_raw;
  logic [XLEN-1:0]     pc_q;
  logic [XLEN-1:0]     imm_q, imm_d, imm_raw;
  logic [XLEN-1:0]     store_q, store_d, store_raw;
  logic [4:0]          rd_q;
  logic                rd_we_q, rd_we_d, wr_raw;
  logic                br_q, br_d, br_raw;
  logic                ill_q, ill_d;
  logic                accept;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & !flush;

  // Instruction decode; an illegal encoding collapses to ADD 0,0 with no side effects
  always_comb begin
    op_raw    = ALU_OP_ADD;
    op1_raw   = '0;
    op2_raw   = '0;
    imm_raw   = '0;
    store_raw = '0;
    br_raw    = 1'b0;
    wr_raw    = 1'b0;
    ill_d     = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        op1_raw = rs1_data;
        op2_raw = (opcode == OPC_OP) ? rs2_data : imm_i;
        imm_raw = (opcode == OPC_OP) ? 32'd0 : imm_i;
        wr_raw  = 1'b1;
        case (funct3)
          3'd0:    op_raw = (opcode == OPC_OP && funct7[5]) ? ALU_OP_SUB : ALU_OP_ADD;
          3'd1:    op_raw = ALU_OP_SLL;
          3'd2:    op_raw = ALU_OP_SLT;
          3'd3:    op_raw = ALU_OP_SLTU;
          3'd4:    op_raw = ALU_OP_XOR;
          3'd5:    op_raw = funct7[5] ? ALU_OP_SRA : ALU_OP_SRL;
          3'd6:    op_raw = ALU_OP_OR;
          3'd7:    op_raw = ALU_OP_AND;
          default: op_raw = ALU_OP_ADD;
        endcase
        // Register ops only accept funct7 0 (or 0x20 on ADD/SUB, SRL/SRA); immediate shifts 0/0x20
        if (opcode == OPC_OP) begin
          ill_d = !((funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
        end else begin
          ill_d = (funct3 == 3'd1 || funct3 == 3'd5) &&
                  !(funct7 == 7'h00 || funct7 == 7'h20);
        end
      end
      OPC_LOAD: begin
        op1_raw = rs1_data;
        op2_raw = imm_i;
        imm_raw = imm_i;
        wr_raw  = 1'b1;
      end
      OPC_STORE: begin
        op1_raw   = rs1_data;
        op2_raw   = imm_s;
        imm_raw   = imm_s;
        store_raw = rs2_data;
      end
      OPC_LUI: begin
        op2_raw = imm_u;
        imm_raw = imm_u;
        wr_raw  = 1'b1;
      end
      OPC_AUIPC: begin
        op1_raw = in_pc;
        op2_raw = imm_u;
        imm_raw = imm_u;
        wr_raw  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op1_raw = in_pc;
        op2_raw = 32'd4;
        imm_raw = (opcode == OPC_JAL) ? imm_j : imm_i;
        wr_raw  = 1'b1;
      end
      OPC_BRANCH: begin
        op1_raw = rs1_data;
        op2_raw = rs2_data;
        imm_raw = imm_b;
        br_raw  = 1'b1;
        case (funct3)
          3'd0:    op_raw = ALU_OP_SEQ;
          3'd1:    op_raw = ALU_OP_SNE;
          3'd4:    op_raw = ALU_OP_SLT;
          3'd5:    op_raw = ALU_OP_SGE;
          3'd6:    op_raw = ALU_OP_SLTU;
          3'd7:    op_raw = ALU_OP_SGEU;
          default: ill_d  = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase

    alu_op_d = ill_d ? ALU_OP_ADD : op_raw;
    op1_d    = ill_d ? '0 : op1_raw;
    op2_d    = ill_d ? '0 : op2_raw;
    imm_d    = ill_d ? '0 : imm_raw;
    store_d  = ill_d ? '0 : store_raw;
    br_d     = !ill_d && br_raw;
    rd_we_d  = !ill_d && wr_raw && (rd_field != 5'd0);
  end

  // Occupancy of the issue register; flush overrides a simultaneous accept
  always_comb begin
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
    end else begin
      out_valid_d = out_ready ? 1'b0 : out_valid_q;
    end
  end

  // Issue register: loads on accept, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= ALU_OP_ADD;
      op1_q       <= '0;
      op2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      store_q     <= '0;
      rd_q        <= 5'd0;
      rd_we_q     <= 1'b0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        alu_op_q <= alu_op_d;
        op1_q    <= op1_d;
        op2_q    <= op2_d;
        pc_q     <= in_pc;
        imm_q    <= imm_d;
        store_q  <= store_d;
        rd_q     <= rd_field;
        rd_we_q  <= rd_we_d;
        br_q     <= br_d;
        ill_q    <= ill_d;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_operator = alu_op_q;
  assign operand1     = op1_q;
  assign operand2     = op2_q;
  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_store    = store_q;
  assign rd           = rd_q;
  assign rd_we        = rd_we_q;
  assign is_branch    = br_q;
  assign illegal      = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode vectors, backpressure, flush,
// asynchronous reset and a randomized run against a transaction-level scoreboard.
module tb_alu_issue_stage;

  localparam logic [3:0] A_ADD = 4'd0,  A_SUB = 4'd1,  A_SLL = 4'd2,  A_SLT = 4'd3;
  localparam logic [3:0] A_SLTU = 4'd4, A_XOR = 4'd5,  A_SRL = 4'd6,  A_SRA = 4'd7;
  localparam logic [3:0] A_OR = 4'd8,   A_AND = 4'd9,  A_SEQ = 4'd10, A_SNE = 4'd11;
  localparam logic [3:0] A_SGE = 4'd12, A_SGEU = 4'd13;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] store;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [3:0]  alu_operator;
  logic [31:0] operand1, operand2, out_pc, out_imm, out_store;
  logic        rd_we, is_branch, illegal;

  int checks = 0;
  int errors = 0;
  iss_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_operator(alu_operator),
    .operand1(operand1), .operand2(operand2), .out_pc(out_pc), .out_imm(out_imm),
    .out_store(out_store), .rd(rd), .rd_we(rd_we), .is_branch(is_branch), .illegal(illegal)
  );

  function automatic iss_t dut_view();
    iss_t v;
    v.op = alu_operator; v.op1 = operand1; v.op2 = operand2; v.pc = out_pc;
    v.imm = out_imm; v.store = out_store; v.rd = rd; v.we = rd_we;
    v.br = is_branch; v.ill = illegal;
    return v;
  endfunction

  // Reference decode from the RV32I encoding rules, immediates via signed shifts.
  function automatic iss_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                      input logic [31:0] a, input logic [31:0] b);
    iss_t r;
    logic [31:0] ii, is_, ib, iu, ij;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok, wr;
    f3 = i[14:12]; f7 = i[31:25];
    ii  = 32'($signed(i) >>> 20);
    is_ = (32'($signed(i) >>> 20) & ~32'h1F) | 32'(i[11:7]);
    ib  = (32'($signed(i) >>> 19) & ~32'hFFF) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
          | (32'(i[11:8]) << 1);
    iu  = i & 32'hFFFFF000;
    ij  = (32'($signed(i) >>> 11) & ~32'hFFFFF) | (32'(i[19:12]) << 12)
          | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    r = '0; r.pc = pc; r.rd = i[11:7]; ok = 1'b1; wr = 1'b0;
    case (i[6:0])
      7'h33, 7'h13: begin
        r.op1 = a; wr = 1'b1;
        r.op2 = (i[6:0] == 7'h33) ? b : ii;
        r.imm = (i[6:0] == 7'h33) ? 32'd0 : ii;
        case (f3)
          3'd0: r.op = (i[6:0] == 7'h33 && f7 == 7'h20) ? A_SUB : A_ADD;
          3'd1: r.op = A_SLL;
          3'd2: r.op = A_SLT;
          3'd3: r.op = A_SLTU;
          3'd4: r.op = A_XOR;
          3'd5: r.op = f7[5] ? A_SRA : A_SRL;
          3'd6: r.op = A_OR;
          default: r.op = A_AND;
        endcase
        if (i[6:0] == 7'h33) ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (f3 == 3'd1 || f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h03: begin r.op1 = a; r.op2 = ii; r.imm = ii; wr = 1'b1; end
      7'h23: begin r.op1 = a; r.op2 = is_; r.imm = is_; r.store = b; end
      7'h37: begin r.op2 = iu; r.imm = iu; wr = 1'b1; end
      7'h17: begin r.op1 = pc; r.op2 = iu; r.imm = iu; wr = 1'b1; end
      7'h6F: begin r.op1 = pc; r.op2 = 32'd4; r.imm = ij; wr = 1'b1; end
      7'h67: begin r.op1 = pc; r.op2 = 32'd4; r.imm = ii; wr = 1'b1; end
      7'h63: begin
        r.op1 = a; r.op2 = b; r.imm = ib; r.br = 1'b1;
        case (f3)
          3'd0: r.op = A_SEQ;
          3'd1: r.op = A_SNE;
          3'd4: r.op = A_SLT;
          3'd5: r.op = A_SGE;
          3'd6: r.op = A_SLTU;
          3'd7: r.op = A_SGEU;
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '0; r.pc = pc; r.rd = i[11:7]; r.ill = 1'b1;
    end else begin
      r.we = wr && (i[11:7] != 5'd0);
    end
    return r;
  endfunction

  function automatic logic [6:0] pick_f7();
    case ($urandom_range(0, 3))
      0: return 7'h00;
      1, 2: return 7'h20;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
      1: begin w[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) w[31:25] = pick_f7(); end
      2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h37;
      5: w[6:0] = 7'h17;
      6: w[6:0] = 7'h6F;
      7: w[6:0] = 7'h67;
      8: w[6:0] = 7'h63;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_instr = instr; in_pc = pc; rs1_data = a; rs2_data = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h00510093, 32'h40, 32'h1, 32'h2);
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || dut_view() !== iss_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got valid=%b fields=%h, want valid=0 fields=0", out_valid, dut_view());
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] ins [7];
    logic [31:0] pcs [7];
    logic [31:0] as_ [7];
    logic [31:0] bs  [7];
    iss_t        exp [7];
    ins[0] = 32'h00510093; pcs[0] = 32'h100; as_[0] = 32'h10;        bs[0] = 32'hDEAD;
    exp[0] = '{op: A_ADD, op1: 32'h10, op2: 32'd5, pc: 32'h100, imm: 32'd5, store: 32'd0,
               rd: 5'd1, we: 1'b1, br: 1'b0, ill: 1'b0};
    ins[1] = 32'h402081B3; pcs[1] = 32'h104; as_[1] = 32'd7;         bs[1] = 32'd9;
    exp[1] = '{op: A_SUB, op1: 32'd7, op2: 32'd9, pc: 32'h104, imm: 32'd0, store: 32'd0,
               rd: 5'd3, we: 1'b1, br: 1'b0, ill: 1'b0};
    ins[2] = 32'h40335293; pcs[2] = 32'h108; as_[2] = 32'h80000000;  bs[2] = 32'd0;
    exp[2] = '{op: A_SRA, op1: 32'h80000000, op2: 32'h403, pc: 32'h108, imm: 32'h403,
               store: 32'd0, rd: 5'd5, we: 1'b1, br: 1'b0, ill: 1'b0};
    ins[3] = 32'h20335293; pcs[3] = 32'h10C; as_[3] = 32'h55;        bs[3] = 32'h66;
    exp[3] = '{op: A_ADD, op1: 32'd0, op2: 32'd0, pc: 32'h10C, imm: 32'd0, store: 32'd0,
               rd: 5'd5, we: 1'b0, br: 1'b0, ill: 1'b1};
    ins[4] = 32'h0020E463; pcs[4] = 32'h110; as_[4] = 32'd1;         bs[4] = 32'hFFFFFFFF;
    exp[4] = '{op: A_SLTU, op1: 32'd1, op2: 32'hFFFFFFFF, pc: 32'h110, imm: 32'd8,
               store: 32'd0, rd: 5'd8, we: 1'b0, br: 1'b1, ill: 1'b0};
    ins[5] = 32'hFE20AE23; pcs[5] = 32'h114; as_[5] = 32'h1000;      bs[5] = 32'hCAFE;
    exp[5] = '{op: A_ADD, op1: 32'h1000, op2: 32'hFFFFFFFC, pc: 32'h114, imm: 32'hFFFFFFFC,
               store: 32'hCAFE, rd: 5'd28, we: 1'b0, br: 1'b0, ill: 1'b0};
    ins[6] = 32'h010000EF; pcs[6] = 32'h200; as_[6] = 32'h77;        bs[6] = 32'h88;
    exp[6] = '{op: A_ADD, op1: 32'h200, op2: 32'd4, pc: 32'h200, imm: 32'h10, store: 32'd0,
               rd: 5'd1, we: 1'b1, br: 1'b0, ill: 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, ins[k], pcs[k], as_[k], bs[k]);
      #1;
      checks++;
      if (rs1_addr !== ins[k][19:15] || rs2_addr !== ins[k][24:20]) begin
        errors++;
        $display("FAIL dir_addr[%0d]: got rs1=%0d rs2=%0d want %0d %0d", k, rs1_addr, rs2_addr,
                 ins[k][19:15], ins[k][24:20]);
      end
      tick();
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      checks++;
      if (out_valid !== 1'b1 || dut_view() !== exp[k]) begin
        errors++;
        $display("FAIL dir_decode[%0d]: got valid=%b %h want valid=1 %h", k, out_valid, dut_view(), exp[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL dir_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    iss_t ea, eb;
    ea = ref_decode(32'h00A00113, 32'h300, 32'h0, 32'h0);
    eb = ref_decode(32'h003100B3, 32'h304, 32'h11, 32'h22);
    out_ready = 1'b0;
    drive(1'b1, 32'h00A00113, 32'h300, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h003100B3, 32'h304, 32'h11, 32'h22);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || dut_view() !== ea) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b %h want rdy=0 vld=1 %h", c, in_ready,
                 out_valid, dut_view(), ea);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1 || dut_view() !== eb) begin
      errors++;
      $display("FAIL bp_next: got vld=%b %h want vld=1 %h", out_valid, dut_view(), eb);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h00510093, 32'h400, 32'h3, 32'h4);
    tick();
    drive(1'b1, 32'h402081B3, 32'h404, 32'h5, 32'h6);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_held: got out_valid=%b want 0", out_valid);
    end
    drive(1'b1, 32'h00510093, 32'h408, 32'h3, 32'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_incoming: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 32'hFE20AE23, 32'h500, 32'h1234, 32'h5678);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got out_valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_view() !== iss_t'(0)) begin
      errors++;
      $display("FAIL rstmid_clear: got vld=%b %h want vld=0 fields=0", out_valid, dut_view());
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic exp_rdy;
    iss_t d;
    q.delete();
    for (int n = 0; n < 800; n++) begin
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), gen_instr(), {$urandom_range(0, 32'h3FFFFFFF), 2'b00},
            $urandom, $urandom);
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      checks++;
      if (in_ready !== exp_rdy || out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_hs[%0d]: got rdy=%b vld=%b want rdy=%b vld=%b", n, in_ready, out_valid,
                 exp_rdy, (q.size() != 0));
      end
      if (q.size() != 0) begin
        checks++;
        if (dut_view() !== q[0]) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got %h want %h", n, dut_view(), q[0]);
        end
      end
      d = ref_decode(in_instr, in_pc, rs1_data, rs2_data);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_rdy) q.push_back(d);
      end
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
